// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain front end of the asynchronous FIFO.
// A 2-entry skid buffer decouples the upstream valid/ready stream from the
// registered full flag. A small state machine sequences pointer flushes and
// holds traffic off while the cleared pointer crosses into the read domain.
// A saturating counter records the cycles in which writes are blocked by full.
module fifo_wr_ctrl #(
  parameter int DSIZE    = 8,
  parameter int CLR_HOLD = 4,
  parameter int CNT_W    = 16
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             s_valid,
  input  logic [DSIZE-1:0] s_data,
  output logic             s_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  input  logic             full,
  output logic             winc,
  output logic [DSIZE-1:0] wdata,
  output logic             wptr_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int HW = $clog2(CLR_HOLD + 1);

  typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [HW-1:0]    hold_cnt;
  logic [1:0]       cnt;
  logic [1:0]       cnt_next;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] tail;
  logic             push;
  logic             pop;

  assign push  = s_valid & s_ready;
  assign pop   = winc;
  assign wdata = head;

  // State register.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= RUN;
    else         state <= state_next;
  end

  // Next state: flush requests are only honoured in RUN; FLUSH lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush_req) state_next = FLUSH;
      FLUSH:   state_next = HOLD;
      HOLD:    if (hold_cnt == '0) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Outputs decoded from state: writes only flow in RUN, busy otherwise.
  always_comb begin
    winc       = 1'b0;
    flush_busy = 1'b0;
    if (state == RUN) winc = (cnt != 2'd0) & ~full;
    else              flush_busy = 1'b1;
  end

  // Hold counter loaded on FLUSH, counts down to zero through HOLD.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)                               hold_cnt <= '0;
    else if (state == FLUSH)                   hold_cnt <= HW'(CLR_HOLD - 1);
    else if (state == HOLD && hold_cnt != '0)  hold_cnt <= hold_cnt - HW'(1);
  end

  // Occupancy after this cycle's push/pop; a flush empties the buffer.
  always_comb begin
    cnt_next = cnt;
    if (state == FLUSH)     cnt_next = 2'd0;
    else if (push && !pop)  cnt_next = cnt + 2'd1;
    else if (pop && !push)  cnt_next = cnt - 2'd1;
  end

  // Skid entries: a pop shifts tail into head, a push fills the first free slot.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      cnt <= cnt_next;
      if (pop && cnt == 2'd2) head <= tail;
      if (push) begin
        if (cnt == 2'd0 || (pop && cnt == 2'd1)) head <= s_data;
        else                                     tail <= s_data;
      end
    end
  end

  // Registered ready and pointer-clear pulse, both derived from next-cycle state.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      s_ready  <= 1'b0;
      wptr_clr <= 1'b0;
    end else begin
      s_ready  <= (cnt_next < 2'd2) && (state_next == RUN);
      wptr_clr <= (state_next == FLUSH);
    end
  end

  // Saturating stall counter; a flush request in RUN wins and clears it.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      stall_cnt <= '0;
    end else if (state == RUN && flush_req) begin
      stall_cnt <= '0;
    end else if (state == RUN && cnt != 2'd0 && full && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: self-checking bench for fifo_wr_ctrl.
// Accepted beats go into a scoreboard queue and are compared against wdata
// whenever winc fires; flushes and resets empty the queue. A narrow stall
// counter is used so that saturation is reachable in a short run.
module tb_fifo_wr_ctrl;

  localparam int DSIZE    = 8;
  localparam int CLR_HOLD = 4;
  localparam int CNT_W    = 4;
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic             wclk = 1'b0;
  logic             wrst_n;
  logic             s_valid;
  logic [DSIZE-1:0] s_data;
  logic             s_ready;
  logic             flush_req;
  logic             flush_busy;
  logic             full;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wptr_clr;
  logic [CNT_W-1:0] stall_cnt;

  int               check_cnt = 0;
  int               pass_cnt  = 0;
  int               wr_total  = 0;
  int               clr_cycles = 0;
  int               busy_cycles = 0;
  logic             toggle_en = 1'b0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [DSIZE-1:0] sb[$];

  fifo_wr_ctrl #(
    .DSIZE   (DSIZE),
    .CLR_HOLD(CLR_HOLD),
    .CNT_W   (CNT_W)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .flush_req (flush_req),
    .flush_busy(flush_busy),
    .full      (full),
    .winc      (winc),
    .wdata     (wdata),
    .wptr_clr  (wptr_clr),
    .stall_cnt (stall_cnt)
  );

  // Free-running write clock, posedges at 5, 15, 25, ...
  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Offer one beat until it is accepted; reports how many edges it took.
  task automatic applyStimulus(input logic [DSIZE-1:0] d, output int waited);
    logic acc;
    acc    = 1'b0;
    waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && waited < 64) begin
      @(negedge wclk);
      acc = s_ready;
      @(posedge wclk);
      #1;
      waited++;
      if (toggle_en) full = ~full;
    end
    s_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'(acc), 1);
  endtask

  // Single-cycle flush request, raised just after an edge.
  task automatic pulseFlush();
    flush_req = 1'b1;
    @(posedge wclk);
    #1;
    flush_req = 1'b0;
  endtask

  // Wait (bounded) for the first RUN cycle after a flush and check ready there.
  task automatic waitFlushDone();
    for (int i = 0; i < 20; i++) begin
      @(negedge wclk);
      if (!flush_busy) break;
    end
    checkOutput("flush_exit", 32'(flush_busy), 0);
    checkOutput("ready_first_run", 32'(s_ready), 1);
    @(posedge wclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  // Monitor at the falling edge: stall model, scoreboard push/pop, flush bookkeeping.
  always @(negedge wclk) begin
    if (!wrst_n) begin
      sb.delete();
      exp_stall = '0;
    end else begin
      checkOutput("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      if (flush_req && !flush_busy)
        exp_stall = '0;
      else if (!flush_busy && full && sb.size() != 0 && exp_stall != STALL_MAX)
        exp_stall = exp_stall + 1'b1;
      if (winc) begin
        checkOutput("winc_while_full", 32'(full), 0);
        checkOutput("winc_while_busy", 32'(flush_busy), 0);
        if (sb.size() == 0) checkOutput("winc_unexpected", 32'(winc), 0);
        else                checkOutput("wdata", 32'(wdata), 32'(sb.pop_front()));
        wr_total++;
      end
      if (s_valid && s_ready) sb.push_back(s_data);
      if (wptr_clr) clr_cycles++;
      if (flush_busy) busy_cycles++;
      if (flush_req && !flush_busy) sb.delete();
    end
  end

  // Main sequence of directed scenarios.
  initial begin
    int w;
    int wsum;
    int mark;
    wrst_n    = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    flush_req = 1'b0;
    full      = 1'b0;

    #2;
    checkOutput("rst_s_ready", 32'(s_ready), 0);
    checkOutput("rst_flush_busy", 32'(flush_busy), 0);
    checkOutput("rst_wptr_clr", 32'(wptr_clr), 0);
    checkOutput("rst_winc", 32'(winc), 0);
    checkOutput("rst_wdata", 32'(wdata), 0);
    checkOutput("rst_stall", 32'(stall_cnt), 0);
    @(posedge wclk);
    @(posedge wclk);
    #3 wrst_n = 1'b1;
    @(negedge wclk);
    checkOutput("ready_before_edge", 32'(s_ready), 0);
    @(posedge wclk);
    #1;
    checkOutput("ready_after_reset", 32'(s_ready), 1);

    $display("[TB] streaming 0x01..0x20 with full low");
    wsum = 0;
    mark = wr_total;
    for (int i = 1; i <= 32; i++) begin
      applyStimulus(DSIZE'(i), w);
      wsum += w;
    end
    checkOutput("stream_accept_cycles", wsum, 32);
    idle(1);
    checkOutput("stream_writes", wr_total - mark, 32);

    $display("[TB] full held while pushing 0xA1..0xA3");
    full = 1'b1;
    applyStimulus(8'hA1, w);
    applyStimulus(8'hA2, w);
    @(negedge wclk);
    checkOutput("ready_held_full", 32'(s_ready), 0);
    repeat (4) @(posedge wclk);
    #1;
    full = 1'b0;
    checkOutput("stall_five", 32'(stall_cnt), 5);
    applyStimulus(8'hA3, w);
    checkOutput("a3_wait", w, 2);
    idle(4);
    checkOutput("drain_full_test", sb.size(), 0);

    $display("[TB] full toggling while streaming 0x00..0x0F");
    toggle_en = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(DSIZE'(i), w);
    toggle_en = 1'b0;
    full = 1'b0;
    idle(4);
    checkOutput("drain_toggle", sb.size(), 0);

    $display("[TB] stall counter saturation");
    full = 1'b1;
    applyStimulus(8'h5A, w);
    idle(20);
    checkOutput("stall_saturated", 32'(stall_cnt), 32'(STALL_MAX));
    full = 1'b0;
    idle(3);

    $display("[TB] flush with two buffered beats");
    full = 1'b1;
    applyStimulus(8'hB1, w);
    applyStimulus(8'hB2, w);
    clr_cycles  = 0;
    busy_cycles = 0;
    mark        = wr_total;
    pulseFlush();
    waitFlushDone();
    checkOutput("flush_clr_cycles", clr_cycles, 1);
    checkOutput("flush_busy_cycles", busy_cycles, 1 + CLR_HOLD);
    checkOutput("flush_stall_clear", 32'(stall_cnt), 0);
    full = 1'b0;
    idle(4);
    checkOutput("flush_dropped", wr_total - mark, 0);

    $display("[TB] second flush request during hold");
    clr_cycles  = 0;
    busy_cycles = 0;
    pulseFlush();
    idle(2);
    pulseFlush();
    waitFlushDone();
    checkOutput("reflush_clr_cycles", clr_cycles, 1);
    checkOutput("reflush_busy_cycles", busy_cycles, 1 + CLR_HOLD);

    $display("[TB] reset during hold");
    full = 1'b1;
    applyStimulus(8'hC1, w);
    applyStimulus(8'hC2, w);
    pulseFlush();
    idle(2);
    #2 wrst_n = 1'b0;
    #1;
    checkOutput("midrst_s_ready", 32'(s_ready), 0);
    checkOutput("midrst_flush_busy", 32'(flush_busy), 0);
    checkOutput("midrst_wptr_clr", 32'(wptr_clr), 0);
    checkOutput("midrst_winc", 32'(winc), 0);
    checkOutput("midrst_wdata", 32'(wdata), 0);
    checkOutput("midrst_stall", 32'(stall_cnt), 0);
    full = 1'b0;
    @(posedge wclk);
    #3 wrst_n = 1'b1;
    #1;
    checkOutput("midrst_ready_low", 32'(s_ready), 0);
    @(posedge wclk);
    #1;
    checkOutput("midrst_ready_high", 32'(s_ready), 1);
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain front end of the asynchronous FIFO, clocked by wclk, sitting directly upstream of the write-pointer/full-flag stage. It accepts a valid/ready data stream into a 2-entry skid buffer and issues winc/wdata to the pointer stage and the dual-port memory only when full is low. It also sequences FIFO flushes by pulsing wptr_clr and holding off traffic while the cleared pointer propagates. It keeps a saturating stall counter for performance monitoring.

## Interface
- DSIZE, 8, data width
- CLR_HOLD, 4, wclk cycles traffic stays blocked after wptr_clr (synchronizer settle time, ≥1)
- CNT_W, 16, stall counter width
- wclk  in  1  write clock
- wrst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream beat valid
- s_data  in  DSIZE  upstream beat data
- s_ready  out  1  registered; buffer can take a beat this cycle
- flush_req  in  1  single-cycle flush request
- flush_busy  out  1  high while in FLUSH or HOLD
- full  in  1  registered full flag from the pointer stage
- winc  out  1  write strobe to the pointer stage and memory
- wdata  out  DSIZE  memory write data; the head skid entry
- wptr_clr  out  1  registered one-cycle pointer-clear pulse
- stall_cnt  out  CNT_W  saturating count of cycles with winc blocked by full

## Operation
- Skid buffer: 2 entries (head, tail), occupancy cnt ∈ {0,1,2}. FIFO order is preserved.
- Accept = s_valid & s_ready. A push goes to head if cnt==0 after any same-cycle pop, else to tail.
- winc = (cnt≠0) & ~full & (state==RUN). This is combinational. A pop happens when winc is high; tail moves to head.
- wdata = head whenever cnt≠0. When cnt==0, wdata holds its last value (don't-care).
- s_ready (registered) = (cnt_next<2) & (state_next==RUN).
- A simultaneous push and pop leaves cnt unchanged, so the stream sustains 1 beat/cycle while full stays low.
- State machine:
  - RUN: normal traffic. flush_req → FLUSH.
  - FLUSH: exactly 1 cycle. wptr_clr=1, cnt←0, winc=0, s_ready=0. Always → HOLD, with hold counter←CLR_HOLD-1.
  - HOLD: winc=0, s_ready=0. Counter decrements each cycle; → RUN when the counter is 0.
- flush_req is ignored while in FLUSH or HOLD.
- stall_cnt increments on each cycle where (cnt≠0) & full & state==RUN. It saturates at all-ones and clears on entering FLUSH.
- Arithmetic: the hold counter is ceil(log2(CLR_HOLD+1)) bits. stall_cnt is CNT_W bits, unsigned, with no wrap.

## Timing
- Reset values: s_ready=0, flush_busy=0, wptr_clr=0, winc=0, wdata=0, stall_cnt=0, cnt=0, state=RUN.
- s_ready rises at the first wclk edge after wrst_n deasserts.
- Latency: a beat accepted at edge N into an empty buffer gives winc=1 in cycle N+1 (if ~full), with wdata = that beat.
- Full handling: full is registered by the pointer stage and already reflects the write just committed, so winc never asserts while full=1 and over_flow never occurs from this block.
  - Full asserted with cnt==2: s_ready=0 until a pop.
  - A pop frees an entry, so s_ready=1 from the next cycle.
- Flush timing: flush_req sampled high in RUN at edge E. Then:
  - winc in the cycle ending at E still commits (the pointer is cleared anyway).
  - Any beat accepted at E is discarded.
  - wptr_clr=1 and flush_busy=1 in cycle E+1.
  - s_ready=0 from cycle E+1.
  - flush_busy falls and state=RUN after CLR_HOLD further cycles.
  - s_ready rises in the first RUN cycle.
- flush_req simultaneous with full: the flush takes priority and stall_cnt clears.
- Reset mid-operation (including mid-HOLD): all state returns immediately to reset values and buffered beats are lost.

## Test plan
- Reset, then continuous s_valid with data 0x01..0x20, full=0 → s_ready=1 from cycle 1, winc high every cycle from cycle 2, and wdata sequence 0x01..0x20 in order with no gaps.
- Hold full=1, push 0xA1, 0xA2, 0xA3 → 0xA1 and 0xA2 accepted, s_ready=0 and 0xA3 held. Release full after 5 cycles → stall_cnt=5, then writes 0xA1, 0xA2, 0xA3 in order.
- Toggle full 1-on/1-off while streaming 0x00..0x0F → no winc while full=1, no beat lost or duplicated, order preserved.
- With cnt=2, pulse flush_req → wptr_clr high exactly 1 cycle, flush_busy high for 1+CLR_HOLD=5 cycles, no winc during that time, stall_cnt=0, and the buffered beats are dropped.
- Pulse flush_req again during HOLD → ignored, with no second wptr_clr and an unchanged exit cycle.
- Assert wrst_n low mid-HOLD with the buffer full → all outputs return to reset values immediately, and s_ready=1 one edge after release.
